// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage.
//   Takes the ALU result (effective address) and forwarded store data from
//   execute, issues at most one valid/ready data-memory request per
//   instruction, aligns store data into byte lanes, formats returning load
//   data, and registers the MEM/WB result. The pipeline is held with
//   mem_stall while an access is outstanding.
//
// Handshake: a request transfers on a rising edge where dmem_req_valid and
//   dmem_req_ready are both high; once valid is raised, dmem_addr, dmem_be,
//   dmem_wdata and dmem_we are held (the stall freezes the MEM inputs) until
//   that transfer. A load response is the single cycle with dmem_rsp_valid
//   high while waiting for it; dmem_rsp_valid at any other time is ignored.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_read, mem_write, funct3      access kind and size/sign
//   alu_result, mem_write_data       address / pass-through value, store data
//   reg_write, rd                    destination write control
//   mem_forward_value                alu_result, combinational
//   mem_stall                        hold upstream stages and MEM inputs
//   dmem_req_*, dmem_we/addr/be/wdata  request channel
//   dmem_rsp_valid, dmem_rdata       load response channel
//   wb_reg_write, wb_rd, wb_value, wb_misaligned  registered MEM/WB result
//   o_dbg_state                      current FSM state (0 IDLE,1 WAIT_ACK,2 WAIT_RSP)
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_write_data,
    input  logic            reg_write,
    input  logic [4:0]      rd,
    output logic [XLEN-1:0] mem_forward_value,
    output logic            mem_stall,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_value,
    output logic            wb_misaligned,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_WAIT_RSP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic            w_mem_op;
    logic            w_is_word;
    logic            w_is_half;
    logic            w_unsigned;
    logic            w_misaligned;
    logic            w_access;
    logic            w_done;
    logic            w_req_valid;
    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_fmt;

    // funct3[1] set means word; 011/110/111 therefore also act as word.
    assign w_off      = alu_result[1:0];
    assign w_mem_op   = mem_read | mem_write;
    assign w_is_word  = funct3[1];
    assign w_is_half  = (funct3[1:0] == 2'b01);
    assign w_unsigned = funct3[2] & ~funct3[1];

    // Only meaningful for memory instructions; a plain ALU op with an odd
    // result must still write its destination.
    assign w_misaligned = w_mem_op &
                          ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));
    assign w_access     = w_mem_op & ~w_misaligned;

    assign mem_forward_value = alu_result;

    // ---------------- request fields ----------------
    assign dmem_we   = mem_write;
    assign dmem_addr = {alu_result[XLEN-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = mem_write_data;
        if (w_is_word) begin
            dmem_be    = 4'b1111;
            dmem_wdata = mem_write_data;
        end else if (w_is_half) begin
            dmem_be    = w_off[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{mem_write_data[15:0]}};
        end else begin
            dmem_be    = 4'b0001 << w_off;
            dmem_wdata = {4{mem_write_data[7:0]}};
        end
    end

    // ---------------- load formatting ----------------
    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (w_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
    end

    assign w_half = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load_fmt = dmem_rdata;
        if (w_is_word) begin
            w_load_fmt = dmem_rdata;
        end else if (w_is_half) begin
            w_load_fmt = w_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
        end else begin
            w_load_fmt = w_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
        end
    end

    // ---------------- access FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // w_done marks the cycle the current access retires; while rst is high
    // nothing is requested and nothing completes.
    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        w_done       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    w_req_valid = w_access;
                    if (w_access) begin
                        if (!dmem_req_ready) begin
                            w_next_state = S_WAIT_ACK;
                        end else if (mem_write) begin
                            w_done = 1'b1;
                        end else begin
                            w_next_state = S_WAIT_RSP;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    w_req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        if (mem_write) begin
                            w_done       = 1'b1;
                            w_next_state = S_IDLE;
                        end else begin
                            w_next_state = S_WAIT_RSP;
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        w_done       = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign dmem_req_valid = w_req_valid;
    assign mem_stall      = w_access & ~w_done;
    assign o_dbg_state    = r_state;

    // ---------------- MEM/WB register ----------------
    // A stalled cycle emits a bubble; rd/value simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg_write  <= 1'b0;
            wb_rd         <= 5'd0;
            wb_value      <= '0;
            wb_misaligned <= 1'b0;
        end else if (!mem_stall) begin
            wb_reg_write  <= reg_write & ~w_misaligned;
            wb_rd         <= rd;
            wb_value      <= mem_read ? w_load_fmt : alu_result;
            wb_misaligned <= w_misaligned;
        end else begin
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] mem_write_data;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] mem_forward_value;
    logic        mem_stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        wb_misaligned;
    logic [1:0]  o_dbg_state;

    mem_stage #(.XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .funct3            (funct3),
        .alu_result        (alu_result),
        .mem_write_data    (mem_write_data),
        .reg_write         (reg_write),
        .rd                (rd),
        .mem_forward_value (mem_forward_value),
        .mem_stall         (mem_stall),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_be           (dmem_be),
        .dmem_wdata        (dmem_wdata),
        .dmem_rsp_valid    (dmem_rsp_valid),
        .dmem_rdata        (dmem_rdata),
        .wb_reg_write      (wb_reg_write),
        .wb_rd             (wb_rd),
        .wb_value          (wb_value),
        .wb_misaligned     (wb_misaligned),
        .o_dbg_state       (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Entry: {reg_write, misaligned, rd[4:0], value[31:0]}
    logic [38:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one popped entry per registered write-back event.
    initial begin
        logic [38:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (wb_reg_write || wb_misaligned)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: got rd=%0d value=0x%08h with empty queue", wb_rd, wb_value);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_reg_write",  {31'd0, wb_reg_write},  {31'd0, e[38]});
                    chk("wb_misaligned", {31'd0, wb_misaligned}, {31'd0, e[37]});
                    chk("wb_rd",         {27'd0, wb_rd},         {27'd0, e[36:32]});
                    chk("wb_value",      wb_value,               e[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_idle();
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        funct3         = 3'b000;
        alu_result     = 32'd0;
        mem_write_data = 32'd0;
        reg_write      = 1'b0;
        rd             = 5'd0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
    endtask

    // Issue one instruction in MEM; entered and left on a falling edge.
    // ack_wait: cycles ready stays low; rsp_wait: idle cycles in WAIT_RSP
    // before the response. exp_wb is the hand-computed write-back value.
    task automatic do_op(input string nm, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic rw, input logic [4:0] rdn,
                         input int ack_wait, input int rsp_wait, input logic [31:0] rdata,
                         input logic exp_mis, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        int  k;
        int  ack_k;
        int  stalls;
        int  exp_stalls;
        bit  acked;
        bit  fin;
        mem_read       = rd_en;
        mem_write      = wr_en;
        funct3         = f3;
        alu_result     = addr;
        mem_write_data = wd;
        reg_write      = rw;
        rd             = rdn;
        dmem_rdata     = rdata;
        k = 0; ack_k = 0; stalls = 0; acked = 0; fin = 0;
        if (exp_mis || !(rd_en || wr_en)) exp_stalls = 0;
        else if (wr_en) exp_stalls = ack_wait;
        else exp_stalls = ack_wait + 1 + rsp_wait;
        while (!fin && k < 40) begin
            dmem_req_ready = (k >= ack_wait);
            dmem_rsp_valid = acked && rd_en && (k >= ack_k + 1 + rsp_wait);
            #1;
            chk({nm, "_fwd"}, mem_forward_value, addr);
            if (mem_stall) stalls++;
            if (exp_mis || !(rd_en || wr_en)) begin
                chk({nm, "_valid"}, {31'd0, dmem_req_valid}, 32'd0);
                fin = 1;
            end else if (!acked) begin
                chk({nm, "_valid"}, {31'd0, dmem_req_valid}, 32'd1);
                chk({nm, "_addr"},  dmem_addr, {addr[31:2], 2'b00});
                chk({nm, "_be"},    {28'd0, dmem_be}, {28'd0, exp_be});
                chk({nm, "_we"},    {31'd0, dmem_we}, {31'd0, wr_en});
                if (wr_en) chk({nm, "_wdata"}, dmem_wdata, exp_wdata);
                if (dmem_req_ready) begin
                    acked = 1;
                    ack_k = k;
                    if (wr_en) fin = 1;
                end
            end else begin
                chk({nm, "_valid_rsp"}, {31'd0, dmem_req_valid}, 32'd0);
                if (dmem_rsp_valid) fin = 1;
            end
            if (fin && (rw || exp_mis)) exp_q.push_back({rw & ~exp_mis, exp_mis, rdn, exp_wb});
            @(negedge clk);
            k++;
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: access did not complete in 40 cycles", nm);
        end
        chk({nm, "_stall_cycles"}, stalls, exp_stalls);
        set_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        set_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state",   {30'd0, o_dbg_state}, 32'd0);
        chk("rst_valid",   {31'd0, dmem_req_valid}, 32'd0);
        chk("rst_wb_rw",   {31'd0, wb_reg_write}, 32'd0);
        chk("rst_wb_rd",   {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_val",  wb_value, 32'd0);
        chk("rst_wb_mis",  {31'd0, wb_misaligned}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //     name   rd wr f3      addr          wdata         rw rd  ack rsp rdata         mis be       wdata         wb
        do_op("sw",   0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0,  0,  0, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        do_op("sb",   0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 0,  3,  0, 32'h0,         0, 4'b1000, 32'hABAB_ABAB, 32'h0);
        do_op("sh",   0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 0,  1,  0, 32'h0,         0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        do_op("sw111",0, 1, 3'b111, 32'h0000_0108, 32'h0102_0304, 0, 0,  0,  0, 32'h0,         0, 4'b1111, 32'h0102_0304, 32'h0);
        do_op("lb",   1, 0, 3'b000, 32'h0000_0102, 32'h0,         1, 5,  0,  1, 32'h00F0_0000, 0, 4'b0100, 32'h0,         32'hFFFF_FFF0);
        do_op("lhu",  1, 0, 3'b101, 32'h0000_0102, 32'h0,         1, 6,  0,  0, 32'h8001_1234, 0, 4'b1100, 32'h0,         32'h0000_8001);
        do_op("lh",   1, 0, 3'b001, 32'h0000_0102, 32'h0,         1, 7,  2,  1, 32'h8001_1234, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
        do_op("lbu",  1, 0, 3'b100, 32'h0000_0101, 32'h0,         1, 8,  0,  0, 32'h0000_8000, 0, 4'b0010, 32'h0,         32'h0000_0080);
        do_op("lw",   1, 0, 3'b010, 32'h0000_0104, 32'h0,         1, 9,  2,  0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0,         32'hCAFE_F00D);
        do_op("lwmis",1, 0, 3'b010, 32'h0000_0101, 32'h0,         1, 10, 0,  0, 32'h1234_5678, 1, 4'b1111, 32'h0,         32'h1234_5678);
        do_op("shmis",0, 1, 3'b001, 32'h0000_0101, 32'h5555_5555, 0, 11, 0,  0, 32'h0,         1, 4'b0011, 32'h0,         32'h0000_0101);
        do_op("alu",  0, 0, 3'b000, 32'h0000_0055, 32'h0,         1, 3,  0,  0, 32'h0,         0, 4'b0001, 32'h0,         32'h0000_0055);

        // Reset while a load waits for its response; the late response is dropped.
        mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0200;
        reg_write = 1'b1; rd = 5'd12; dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("rsp_wait_state", {30'd0, o_dbg_state}, 32'd2);
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", {30'd0, o_dbg_state}, 32'd0);
        chk("rst_mid_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("rst_mid_wb_rd", {27'd0, wb_rd}, 32'd0);
        set_idle();
        rst = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFFFF_FFFF;
        #1;
        chk("stale_rsp_stall", {31'd0, mem_stall}, 32'd0);
        chk("stale_rsp_valid", {31'd0, dmem_req_valid}, 32'd0);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("stale_rsp_state", {30'd0, o_dbg_state}, 32'd0);
        chk("stale_rsp_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("stale_rsp_wb_val", wb_value, 32'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
